csa_final_adder: RTL
====================

Name: csa_final_adder

Overview:
- Pipelined stage that sits directly downstream of the 6:3 compressor in the CSA tree.
- Accepts the three redundant K-bit vectors (c, o, s), merges them 3:2, and resolves the result to a single binary K-bit sum with a split, carry-pipelined carry-propagate adder.
- Uses a valid/ready handshake so the NTT datapath can stall it.
- Result is (c + o + s) mod 2^K.

Parameters:
- K, 64, operand/result bit-width (K >= 4).
- LO_W, K/2, width of the low half of the carry-propagate adder (1 <= LO_W <= K-1); the high half is K-LO_W bits.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  c/o/s carry a valid operand triple.
- in_ready  output  1  stage accepts the triple this cycle.
- in_c  input  K  carry vector from the 6:3 stage (weight as supplied; bits [1:0] normally 0).
- in_o  input  K  second-carry vector (bit 0 normally 0).
- in_s  input  K  sum vector.
- out_valid  output  1  out_sum is valid.
- out_ready  input  1  consumer accepts out_sum.
- out_sum  output  K  (in_c + in_o + in_s) mod 2^K.

Behaviour:
- Handshake: a transfer occurs on a cycle where valid && ready. The producer holds data stable while valid && !ready.
- Pipeline enable: en = out_ready | ~out_valid. All three stages advance together only when en = 1. In base build, in_ready = en (combinational from out_ready).
- Stage 1 (register P1), on en:
  - p1_v <= in_valid.
  - If in_valid, capture 3:2 compression of the inputs.
  - s2[i] = c^o^s.
  - m2 = {maj(c,o,s)[K-2:0], 1'b0}; MSB carry-out of the majority is dropped (mod 2^K).
- Stage 2 (register P2), on en:
  - p2_v <= p1_v.
  - {cy, lo} = s2[LO_W-1:0] + m2[LO_W-1:0].
  - Register lo, cy, and the untouched high halves s2[K-1:LO_W], m2[K-1:LO_W].
- Stage 3 (register P3 = output), on en:
  - out_valid <= p2_v.
  - out_sum <= {hi_s + hi_m + cy, lo}, truncated to K bits; the final carry-out is discarded.
- Latency: exactly 3 cycles from accepted input to out_valid with no stall. Throughput is 1 result/cycle while out_ready = 1.
- Bubbles: stage registers whose valid is 0 may hold stale data. out_sum is don't-care when out_valid = 0, but must not change while out_valid && !out_ready.
- Stall: when out_valid && !out_ready, every stage holds; in_ready = 0; no input is consumed or lost.
- Reset: rst has priority over en.
  - All valid bits clear next edge: p1_v, p2_v, out_valid = 0.
  - out_sum = 0, data registers = 0.
  - Any in-flight results are discarded. in_ready = 1 in the cycle after reset (base build).
- Simultaneous out_ready drop and new in_valid: the input is not accepted (in_ready = 0 that cycle).
- Arithmetic is unsigned, modulo 2^K. No saturation, no overflow flag.

Optional Feature:
- Macro: CSA_FINAL_SKID_EN.
- Defined:
  - A 2-entry output skid buffer is added after P3.
  - in_ready becomes a registered signal: 1 iff the skid has at least 2 free entries after accounting for in-flight valids.
  - The core pipeline advances whenever in_ready was 1, so there is no combinational path from out_ready to in_ready.
  - Latency is still 3 cycles when the skid is empty (bypass).
  - Full throughput with out_ready continuously 1.
  - Reset empties the skid.
- Not defined: behaviour exactly as above, with in_ready = en.

Test Plan:
- K=8, LO_W=4; rst for 2 cycles -> out_valid = 0, out_sum = 0x00, in_ready = 1.
- in_c = 0x04, in_o = 0x02, in_s = 0x01, out_ready = 1 -> out_sum = 0x07 with out_valid exactly 3 cycles after acceptance.
- Wrap-around: all inputs 0xFF -> out_sum = 0xFD. Low-half carry case c = 0x08, o = 0x08, s = 0x00 -> 0x10.
- Back-to-back stream of 20 random triples, out_ready = 1 -> 20 results in order, one per cycle, each equal to the sum mod 256.
- Backpressure: drop out_ready for 5 cycles mid-stream -> out_sum held stable, in_ready = 0 (base build), no loss or duplication after release.
- Reset asserted while 3 results are in flight -> no out_valid until new input is accepted. First post-reset triple (0x10, 0x20, 0x30) -> 0x60.

Source files
------------

// File: rtl/csa_final_adder.sv
// Purpose: 3:2 merge of (c, o, s) and split carry-pipelined CPA giving (c + o + s) mod 2^K.
// Latency: 3 cycles from accepted input to out_valid; 1 result/cycle while out_ready = 1.
// Backpressure: all stages hold while out_valid && !out_ready; optional CSA_FINAL_SKID_EN adds a 2-entry skid and registered in_ready.
module csa_final_adder #(
    parameter int K    = 64,
    parameter int LO_W = K / 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [K-1:0] in_c,
    input  logic [K-1:0] in_o,
    input  logic [K-1:0] in_s,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [K-1:0] out_sum
);

    localparam int HI_W = K - LO_W;

    logic            en;

    logic            p1_v;
    logic [K-1:0]    p1_s;
    logic [K-1:0]    p1_m;

    logic            p2_v;
    logic            p2_cy;
    logic [LO_W-1:0] p2_lo;
    logic [HI_W-1:0] p2_hs;
    logic [HI_W-1:0] p2_hm;

    logic            p3_v;
    logic [K-1:0]    p3_sum;

    // Majority carry-out of the top bit falls off the modulo-2^K result.
    logic [K-2:0]    maj;
    logic [LO_W:0]   lo_add;
    logic [HI_W-1:0] hi_add;

    assign maj    = (in_c[K-2:0] & in_o[K-2:0]) |
                    (in_c[K-2:0] & in_s[K-2:0]) |
                    (in_o[K-2:0] & in_s[K-2:0]);
    assign lo_add = {1'b0, p1_s[LO_W-1:0]} + {1'b0, p1_m[LO_W-1:0]};
    assign hi_add = p2_hs + p2_hm + HI_W'(p2_cy);

    always_ff @(posedge clk) begin
        if (rst) begin
            p1_v <= 1'b0;
            p1_s <= '0;
            p1_m <= '0;
        end else if (en) begin
            p1_v <= in_valid;
            if (in_valid) begin
                p1_s <= in_c ^ in_o ^ in_s;
                p1_m <= {maj, 1'b0};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            p2_v  <= 1'b0;
            p2_cy <= 1'b0;
            p2_lo <= '0;
            p2_hs <= '0;
            p2_hm <= '0;
        end else if (en) begin
            p2_v  <= p1_v;
            p2_cy <= lo_add[LO_W];
            p2_lo <= lo_add[LO_W-1:0];
            p2_hs <= p1_s[K-1:LO_W];
            p2_hm <= p1_m[K-1:LO_W];
        end
    end

`ifdef CSA_FINAL_SKID_EN
    logic [1:0]   sk_cnt;
    logic [1:0]   cnt_nxt;
    logic [K-1:0] sk0;
    logic [K-1:0] sk1;
    logic         rdy_q;
    logic         p3v_nxt;
    logic         pop_p3;
    logic         pop_sk;
    logic         push;

    // Skid entries are always older than P3, so the output drains the skid first.
    assign en        = rdy_q;
    assign in_ready  = rdy_q;
    assign out_valid = (sk_cnt != 2'd0) | p3_v;
    assign out_sum   = (sk_cnt != 2'd0) ? sk0 : p3_sum;
    assign pop_p3    = out_ready & p3_v & (sk_cnt == 2'd0);
    assign pop_sk    = out_ready & (sk_cnt != 2'd0);
    assign push      = en & p3_v & ~pop_p3;

    always_comb begin
        cnt_nxt = sk_cnt;
        if (push && !pop_sk) begin
            cnt_nxt = sk_cnt + 2'd1;
        end else if (!push && pop_sk) begin
            cnt_nxt = sk_cnt - 2'd1;
        end
        p3v_nxt = en ? p2_v : (p3_v & ~pop_p3);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sk_cnt <= 2'd0;
            sk0    <= '0;
            sk1    <= '0;
            rdy_q  <= 1'b1;
        end else begin
            sk_cnt <= cnt_nxt;
            rdy_q  <= ({1'b0, cnt_nxt} + {2'b00, p3v_nxt}) <= 3'd1;
            if (pop_sk) begin
                sk0 <= (push && sk_cnt == 2'd1) ? p3_sum : sk1;
                if (push) begin
                    sk1 <= p3_sum;
                end
            end else if (push) begin
                if (sk_cnt == 2'd0) begin
                    sk0 <= p3_sum;
                end else begin
                    sk1 <= p3_sum;
                end
            end
        end
    end
`else
    assign en        = out_ready | ~p3_v;
    assign in_ready  = en;
    assign out_valid = p3_v;
    assign out_sum   = p3_sum;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            p3_v   <= 1'b0;
            p3_sum <= '0;
        end else if (en) begin
            p3_v   <= p2_v;
            p3_sum <= {hi_add, p2_lo};
        end
`ifdef CSA_FINAL_SKID_EN
        else if (pop_p3) begin
            p3_v <= 1'b0;
        end
`endif
    end

endmodule
